// File: rtl/vmul_pkg.sv
// Shared types, step counts and the byte-pair schedule for the iterative
// 8x8-based vector multiplier.
package vmul_pkg;

  // Lane configuration selected per operation.
  typedef enum logic [1:0] {
    MODE_8    = 2'b00,
    MODE_16   = 2'b01,
    MODE_32   = 2'b10,
    MODE_RSVD = 2'b11
  } vmul_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } vmul_state_e;

  // Number of 8x8 partial products needed per mode.
  localparam int STEPS_8  = 4;
  localparam int STEPS_16 = 8;
  localparam int STEPS_32 = 16;

  // Byte indices into operand_a (i) and operand_b (j) for one step.
  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
  } byte_pair_t;

  // Maps a step number to the byte pair multiplied in that step. Pairs
  // never straddle a lane, so lane products stay inside their field.
  function automatic byte_pair_t step_to_pair(vmul_mode_e mode, logic [3:0] s);
    byte_pair_t p;
    p.i = 2'd0;
    p.j = 2'd0;
    case (mode)
      MODE_8: begin
        p.i = s[1:0];
        p.j = s[1:0];
      end
      MODE_16: begin
        p.i = {s[2], s[0]};
        p.j = {s[2], s[1]};
      end
      MODE_32: begin
        p.i = s[1:0];
        p.j = s[3:2];
      end
      default: begin
        p.i = 2'd0;
        p.j = 2'd0;
      end
    endcase
    return p;
  endfunction

  // Value of the step counter on the final RUN cycle.
  function automatic logic [3:0] last_step(vmul_mode_e mode);
    logic [3:0] n;
    case (mode)
      MODE_8:  n = 4'(STEPS_8 - 1);
      MODE_16: n = 4'(STEPS_16 - 1);
      MODE_32: n = 4'(STEPS_32 - 1);
      default: n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vmul_iter_8x8_if.sv
// Operand/result handshake bundle of the iterative vector multiplier.
interface vmul_iter_8x8_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        out_err;

  // Requester side: issues operations and consumes results.
  modport master (
    output in_valid, operand_a, operand_b, mode, out_ready,
    input  in_ready, out_valid, result, out_err
  );

  // Multiplier side.
  modport slave (
    input  in_valid, operand_a, operand_b, mode, out_ready,
    output in_ready, out_valid, result, out_err
  );
endinterface

// File: rtl/multiplier_8bit.sv
// Combinational unsigned 8x8 -> 16 multiplier core shared by all steps.
module multiplier_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

// File: rtl/vmul_iter_8x8.sv
// Iterative vector multiplier: one 8x8 product per cycle, shifted and
// accumulated into a 64-bit result holding 4x16, 2x32 or 1x64 lane products.
module vmul_iter_8x8
  import vmul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  vmul_iter_8x8_if.slave  bus
);

  vmul_state_e state_reg, state_next;
  logic [3:0]  s_reg, s_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  vmul_mode_e  mode_reg, mode_next;
  logic [63:0] acc_reg, acc_next;

  logic [7:0]  a_byte [4];
  logic [7:0]  b_byte [4];
  byte_pair_t  pair;
  logic [7:0]  a_sel;
  logic [7:0]  b_sel;
  logic [15:0] pp;
  logic [2:0]  byte_sum;
  logic [5:0]  shamt;
  logic [63:0] addend;

  // Split the latched operands into bytes for the per-step selection.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign a_byte[gi] = a_reg[8*gi +: 8];
      assign b_byte[gi] = b_reg[8*gi +: 8];
    end
  endgenerate

  assign pair  = step_to_pair(mode_reg, s_reg);
  assign a_sel = a_byte[pair.i];
  assign b_sel = b_byte[pair.j];

  multiplier_8bit u_mult (
    .a (a_sel),
    .b (b_sel),
    .p (pp)
  );

  // Weight of byte pair (i, j) is 2^(8*(i+j)) in every mode.
  assign byte_sum = {1'b0, pair.i} + {1'b0, pair.j};
  assign shamt    = {byte_sum, 3'b000};
  assign addend   = {48'd0, pp} << shamt;

  // Next-state, step counter and accumulator update.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    mode_next  = mode_reg;
    acc_next   = acc_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.operand_a;
          b_next     = bus.operand_b;
          mode_next  = vmul_mode_e'(bus.mode);
          acc_next   = 64'd0;
          s_next     = 4'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Reserved mode spends one cycle here without accumulating.
        if (mode_reg != MODE_RSVD) begin
          acc_next = acc_reg + addend;
        end
        if (s_reg == last_step(mode_reg)) begin
          s_next     = 4'd0;
          state_next = DONE;
        end else begin
          s_next = s_reg + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= 4'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      mode_reg  <= MODE_8;
      acc_reg   <= 64'd0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      mode_reg  <= mode_next;
      acc_reg   <= acc_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = acc_reg;
  assign bus.out_err   = (state_reg == DONE) && (mode_reg == MODE_RSVD);

endmodule

// File: doc/vmul_iter_8x8.md
# vmul_iter_8x8

Sequential vector multiplier that computes 8-bit, 16-bit or 32-bit lane products of two 32-bit operands by time-multiplexing a single `multiplier_8bit` core. It sits directly downstream of that core and consumes its 16-bit partial products. It shifts them and accumulates them into a 64-bit result, using valid/ready handshakes on both sides. It is the area-optimised alternative to the fully parallel 32-bit vector multiplier.

## Interface
- Parameters: none; all widths are fixed.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair and mode are valid.
- `in_ready` output 1: block accepts a new operation.
- `operand_a` input 32: multiplicand, packed lanes, lane 0 in the LSBs.
- `operand_b` input 32: multiplier, same packing.
- `mode` input 2: 00 = 4×8-bit lanes, 01 = 2×16-bit lanes, 10 = 1×32-bit lane, 11 = reserved.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `result` output 64: lane L product sits at bits [2W·L +: 2W], where W is the lane width.
- `out_err` output 1: the operation used reserved mode 11; qualified by `out_valid`.

## Operation
- All operands and products are unsigned.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `operand_a`, `operand_b` and `mode`; clear `acc`; set step counter `s`=0; go to RUN.
  - RUN: on each cycle, `acc` += zero-extend(`pp`) << 8·(i+j). `pp` = `multiplier_8bit`(a_byte[i], b_byte[j]). When `s`==N−1, go to DONE; otherwise increment `s`.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Byte-pair schedule:
  - Mode 00, N=4: i=j=s.
  - Mode 01, N=8: L=s[2], i=2L+s[0], j=2L+s[1].
  - Mode 10, N=16: i=s[1:0], j=s[3:2].
  - Mode 11, N=1: no accumulation; `result`=0, `out_err`=1.
- The shift is 8·(i+j) in every mode. Lane products never exceed their lane field, so no carry crosses a lane boundary. Addition is modulo 2^64, and overflow cannot occur.
- `result` is driven from `acc` and is stable during DONE.
- `in_ready` is 0 in RUN and DONE. `in_valid` is ignored there, and operands are not sampled.
- The latched `mode` and operands are used for the whole operation; input changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `out_err`=0, `s`=0.
- Reset assertion at any time, including mid-RUN or in DONE, aborts the operation immediately. No partial result is emitted.
- If acceptance happens on edge T, the first `out_valid`=1 cycle follows edge T+N.
- The result is held until the cycle in which `out_valid` and `out_ready` are both 1. `in_ready` returns to 1 on the next edge.
- Minimum initiation interval is N+2 cycles: 6, 10 or 18.
- `multiplier_8bit` is combinational, so the byte muxes, `multiplier_8bit` and the 64-bit adder form one cycle path. There is no pipelining inside RUN.

## Structure
- Package `vmul_pkg` contains:
  - `vmul_mode_e` (MODE_8, MODE_16, MODE_32, MODE_RSVD).
  - `vmul_state_e` (IDLE, RUN, DONE).
  - Constants STEPS_8=4, STEPS_16=8, STEPS_32=16.
  - Function `step_to_pair(mode, s)` returning i and j.
- One `multiplier_8bit` sub-module instance. The FSM, byte muxes and accumulator live in this module; no other sub-module is needed.

## Test plan
- Mode 10, a=b=0xFFFFFFFF → `result`=0xFFFFFFFE00000001, `out_err`=0, `out_valid` 16 cycles after acceptance.
- Mode 00, a=0xFF100302, b=0xFF100507 → `result`=0xFE010100000F000E, `out_valid` after 4 cycles.
- Mode 01, a=0xFFFF1234, b=0xFFFF0002 → `result`=0xFFFE000100002468, `out_valid` after 8 cycles.
- Mode 10 op, `out_ready` held low 5 cycles in DONE, while `in_valid` is pulsed with new operands:
  - `result` stays unchanged and `in_ready` stays 0.
  - The new operands are not taken.
  - After the handshake, `in_ready` returns to 1 on the next cycle.
- `rst_n` low at `s`=5 of a mode 10 op:
  - `out_valid`=0, `result`=0 and `in_ready`=1 immediately.
  - A following mode 00 op with a=b=0x02020202 yields 0x0004000400040004.
- Mode 11, any operands → `out_valid` 1 cycle after acceptance, `result`=0, `out_err`=1.
